// File: rtl/ifid_queue_pkg.sv
// Shared defaults for the IF->ID instruction queue, so IF, ID and the queue agree on
// instruction/PC widths, depth and the bubble instruction. Also holds the per-edge operation decode.
package ifid_queue_pkg;

    localparam int          IFID_IW    = 16;
    localparam int          IFID_AW    = 16;
    localparam int          IFID_DEPTH = 4;
    localparam logic [15:0] IFID_NOP   = 16'h0000;

    typedef enum logic [2:0] {
        Q_IDLE,
        Q_PUSH,
        Q_POP,
        Q_BOTH,
        Q_FLUSH
    } q_op_e;

    // Flush dominates; otherwise push and pop are independent and may coincide.
    function automatic q_op_e q_op(input logic push, input logic pop, input logic flush);
        q_op_e op;
        if (flush)              op = Q_FLUSH;
        else if (push && pop)   op = Q_BOTH;
        else if (push)          op = Q_PUSH;
        else if (pop)           op = Q_POP;
        else                    op = Q_IDLE;
        return op;
    endfunction

endpackage

// File: rtl/ifid_ptr.sv
// Wrapping queue pointer with increment enable and synchronous clear.
// DEPTH is a power of two, so the natural binary rollover is the modulo-DEPTH wrap.
module ifid_ptr #(
    parameter  int DEPTH = 4,
    localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic          C,
    input  logic          R,
    input  logic          clr,
    input  logic          inc,
    output logic [PW-1:0] ptr
);

    logic [PW-1:0] ptr_q;
    logic [PW-1:0] ptr_d;

    always_comb begin
        ptr_d = ptr_q;
        if (clr) begin
            ptr_d = '0;
        end else if (inc) begin
            ptr_d = ptr_q + 1'b1;
        end
    end

    always_ff @(posedge C or posedge R) begin
        if (R) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign ptr = ptr_q;

endmodule

// File: rtl/ifid_queue.sv
// IF->ID decoupling queue: small FIFO of {instruction, PC} with flush and stall.
// Head outputs come from state only; the fill level is its own register, not a pointer difference.
module ifid_queue
    import ifid_queue_pkg::*;
#(
    parameter  int          IW    = IFID_IW,
    parameter  int          AW    = IFID_AW,
    parameter  int          DEPTH = IFID_DEPTH,
    parameter  logic [IW-1:0] NOP = IW'(IFID_NOP),
    localparam int          PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int          CW    = $clog2(DEPTH) + 1
) (
    input  logic          C,
    input  logic          R,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [IW-1:0] in_instr,
    input  logic [AW-1:0] in_pc,
    input  logic          flush,
    input  logic          stall,
    output logic          out_valid,
    output logic [IW-1:0] out_instr,
    output logic [AW-1:0] out_pc,
    output logic [CW-1:0] count
);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;
    logic [PW-1:0] head;
    logic [PW-1:0] tail;
    logic          push;
    logic          pop;
    q_op_e         op;

    logic [IW-1:0] instr_mem [DEPTH];
    logic [AW-1:0] pc_mem    [DEPTH];

    // Readiness looks only at the held count, so a full queue refuses even when a pop happens.
    assign in_ready  = (count_q < CW'(DEPTH));
    assign out_valid = (count_q != '0);

    assign push = in_valid & in_ready & ~flush;
    assign pop  = out_valid & ~stall & ~flush;
    assign op   = q_op(push, pop, flush);

    always_comb begin
        count_d = count_q;
        case (op)
            Q_FLUSH: count_d = '0;
            Q_PUSH:  count_d = count_q + 1'b1;
            Q_POP:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge C or posedge R) begin
        if (R) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    ifid_ptr #(.DEPTH(DEPTH)) u_head (
        .C   (C),
        .R   (R),
        .clr (op == Q_FLUSH),
        .inc ((op == Q_POP) || (op == Q_BOTH)),
        .ptr (head)
    );

    ifid_ptr #(.DEPTH(DEPTH)) u_tail (
        .C   (C),
        .R   (R),
        .clr (op == Q_FLUSH),
        .inc ((op == Q_PUSH) || (op == Q_BOTH)),
        .ptr (tail)
    );

    // Storage is never reset; stale entries are masked by out_valid below.
    always_ff @(posedge C) begin
        if (push) begin
            instr_mem[tail] <= in_instr;
            pc_mem[tail]    <= in_pc;
        end
    end

    assign out_instr = out_valid ? instr_mem[head] : NOP;
    assign out_pc    = out_valid ? pc_mem[head]    : '0;
    assign count     = count_q;

endmodule
